// File: rtl/iseq_arbiter_if.sv
// iseq_arbiter_if: request/grant bundle between sequence sources and iseq_arbiter; ISEQ_ARB_STATS_EN adds grant statistics
interface iseq_arbiter_if;
  logic dfi_init_complete, app_req, app_done, aref_req, zq_req, prd_req, maint_done;
  logic grant_app, grant_maint, aref_ack, zq_ack, prd_ack, aref_overflow, timeout_err;
  logic [1:0] maint_sel;
  logic [3:0] aref_pending;
`ifdef ISEQ_ARB_STATS_EN
  logic [15:0] stat_app_grants, stat_aref_forced;
  modport master (
    output dfi_init_complete, app_req, app_done, aref_req, zq_req, prd_req, maint_done,
    input grant_app, grant_maint, maint_sel, aref_ack, zq_ack, prd_ack, aref_pending,
    input aref_overflow, timeout_err, stat_app_grants, stat_aref_forced
  );
  modport slave (
    input dfi_init_complete, app_req, app_done, aref_req, zq_req, prd_req, maint_done,
    output grant_app, grant_maint, maint_sel, aref_ack, zq_ack, prd_ack, aref_pending,
    output aref_overflow, timeout_err, stat_app_grants, stat_aref_forced
  );
`else
  modport master (
    output dfi_init_complete, app_req, app_done, aref_req, zq_req, prd_req, maint_done,
    input grant_app, grant_maint, maint_sel, aref_ack, zq_ack, prd_ack, aref_pending,
    input aref_overflow, timeout_err
  );
  modport slave (
    input dfi_init_complete, app_req, app_done, aref_req, zq_req, prd_req, maint_done,
    output grant_app, grant_maint, maint_sel, aref_ack, zq_ack, prd_ack, aref_pending,
    output aref_overflow, timeout_err
  );
`endif
endinterface

// File: rtl/iseq_arbiter.sv
// iseq_arbiter: picks app or maintenance sequence for the DFI path, tracks postponed refreshes, times out grants; ISEQ_ARB_STATS_EN adds grant counters
module iseq_arbiter #(
  parameter int MAX_POSTPONE = 8,
  parameter int TIMEOUT = 4096
) (
  input logic clk,
  input logic rst,
  iseq_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, APP, MAINT} state_t;
  state_t state;
  logic init_q, zq_pend, prd_pend;
  logic [15:0] tmr;
  logic en, forced, d_zq, d_prd, d_app, d_aref, d_maint, done, to, fin;
  always_comb begin
    en = state == IDLE && init_q && bus.dfi_init_complete;
    forced = bus.aref_pending == 4'(MAX_POSTPONE);
    d_zq = en && !forced && zq_pend;
    d_prd = en && !forced && !zq_pend && prd_pend;
    d_app = en && !forced && !zq_pend && !prd_pend && bus.app_req;
    d_aref = en && (forced || (!zq_pend && !prd_pend && !bus.app_req && bus.aref_pending != 4'd0));
    d_maint = d_zq || d_prd || d_aref;
    done = state == APP ? bus.app_done : state == MAINT ? bus.maint_done : 1'b0;
    to = tmr == 16'(TIMEOUT - 1);
    fin = state != IDLE && (done || to);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      init_q <= 1'b0;
      zq_pend <= 1'b0;
      prd_pend <= 1'b0;
      tmr <= 16'd0;
      bus.grant_app <= 1'b0;
      bus.grant_maint <= 1'b0;
      bus.maint_sel <= 2'b00;
      bus.aref_ack <= 1'b0;
      bus.zq_ack <= 1'b0;
      bus.prd_ack <= 1'b0;
      bus.aref_pending <= 4'd0;
      bus.aref_overflow <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      init_q <= bus.dfi_init_complete;
      zq_pend <= bus.zq_req || (zq_pend && !d_zq);
      prd_pend <= bus.prd_req || (prd_pend && !d_prd);
      bus.aref_pending <= bus.aref_req && !d_aref && !forced ? bus.aref_pending + 4'd1
                        : !bus.aref_req && d_aref ? bus.aref_pending - 4'd1 : bus.aref_pending;
      bus.aref_overflow <= bus.aref_overflow || (bus.aref_req && !d_aref && forced);
      bus.timeout_err <= bus.timeout_err || (fin && !done);
      tmr <= state == IDLE ? 16'd0 : tmr + 16'd1;
      state <= d_app ? APP : d_maint ? MAINT : fin ? IDLE : state;
      bus.grant_app <= d_app || (state == APP && !fin);
      bus.grant_maint <= d_maint || (state == MAINT && !fin);
      bus.maint_sel <= d_aref ? 2'b01 : d_zq ? 2'b10 : d_prd ? 2'b11
                     : state == MAINT && !fin ? bus.maint_sel : 2'b00;
      bus.aref_ack <= d_aref;
      bus.zq_ack <= d_zq;
      bus.prd_ack <= d_prd;
    end
`ifdef ISEQ_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.stat_app_grants <= 16'd0;
      bus.stat_aref_forced <= 16'd0;
    end else begin
      bus.stat_app_grants <= bus.stat_app_grants + 16'(d_app && !(&bus.stat_app_grants));
      bus.stat_aref_forced <= bus.stat_aref_forced + 16'(d_aref && forced && !(&bus.stat_aref_forced));
    end
`endif
endmodule

// File: tb/tb_iseq_arbiter.sv
// tb_iseq_arbiter: directed plus randomized checks of iseq_arbiter against a sequence-level reference model
module tb_iseq_arbiter;
  localparam int MAXP = 8;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  iseq_arbiter_if bus();
  iseq_arbiter #(.MAX_POSTPONE(MAXP), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  int n = 0;
  int m_kind = 0, m_held = 0, m_cnt = 0, m_pick = 0, m_ack = 0;
  logic m_zq = 1'b0, m_prd = 1'b0, m_ovf = 1'b0, m_err = 1'b0, m_init_prev = 1'b0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_kind = 0; m_held = 0; m_cnt = 0; m_pick = 0; m_ack = 0;
      m_zq = 0; m_prd = 0; m_ovf = 0; m_err = 0; m_init_prev = 0;
    end else begin
      m_pick = 0;
      if (m_kind == 0 && m_init_prev && bus.dfi_init_complete) begin
        if (m_cnt == MAXP) m_pick = 2;
        else if (m_zq) m_pick = 3;
        else if (m_prd) m_pick = 4;
        else if (bus.app_req) m_pick = 1;
        else if (m_cnt > 0) m_pick = 2;
      end
      if (m_kind != 0) begin
        m_held++;
        if (m_kind == 1 ? bus.app_done : bus.maint_done) m_kind = 0;
        else if (m_held == TO) begin
          m_kind = 0;
          m_err = 1;
        end
      end
      m_zq = bus.zq_req || (m_zq && m_pick != 3);
      m_prd = bus.prd_req || (m_prd && m_pick != 4);
      if (bus.aref_req && m_pick != 2) begin
        if (m_cnt == MAXP) m_ovf = 1;
        else m_cnt++;
      end else if (!bus.aref_req && m_pick == 2) m_cnt--;
      if (m_pick != 0) begin
        m_kind = m_pick;
        m_held = 0;
      end
      m_ack = m_pick;
      m_init_prev = bus.dfi_init_complete;
    end
  always @(negedge clk)
    if (!rst) begin
      chk("grant_app", int'(bus.grant_app), int'(m_kind == 1));
      chk("grant_maint", int'(bus.grant_maint), int'(m_kind >= 2));
      chk("maint_sel", int'(bus.maint_sel), m_kind >= 2 ? m_kind - 1 : 0);
      chk("aref_ack", int'(bus.aref_ack), int'(m_ack == 2));
      chk("zq_ack", int'(bus.zq_ack), int'(m_ack == 3));
      chk("prd_ack", int'(bus.prd_ack), int'(m_ack == 4));
      chk("aref_pending", int'(bus.aref_pending), m_cnt);
      chk("aref_overflow", int'(bus.aref_overflow), int'(m_ovf));
      chk("timeout_err", int'(bus.timeout_err), int'(m_err));
      chk("exclusive", int'(bus.grant_app && bus.grant_maint), 0);
    end
  task automatic wait_grant(input string name);
    int k = 0;
    while (!(bus.grant_app || bus.grant_maint) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_wait"}, int'(k < 100), 1);
  endtask
  task automatic serve(input string name, input logic exp_app, input logic [1:0] exp_sel, input logic [2:0] exp_ack);
    wait_grant(name);
    chk({name, "_app"}, int'(bus.grant_app), int'(exp_app));
    chk({name, "_sel"}, int'(bus.maint_sel), int'(exp_sel));
    chk({name, "_ack"}, int'({bus.aref_ack, bus.zq_ack, bus.prd_ack}), int'(exp_ack));
    if (exp_app) bus.app_req = 0;
    cyc(1);
    chk({name, "_ack_end"}, int'({bus.aref_ack, bus.zq_ack, bus.prd_ack}), 0);
    cyc(8);
    if (exp_app) bus.app_done = 1;
    else bus.maint_done = 1;
    cyc(1);
    bus.app_done = 0;
    bus.maint_done = 0;
  endtask
  initial begin
    bus.dfi_init_complete = 0; bus.app_req = 0; bus.app_done = 0; bus.aref_req = 0;
    bus.zq_req = 0; bus.prd_req = 0; bus.maint_done = 0;
    cyc(2);
    bus.dfi_init_complete = 1;
    bus.app_req = 1;
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 chk("rst_lat1", int'(bus.grant_app), 0);
    @(posedge clk); #1 chk("rst_lat2", int'(bus.grant_app), 1);
    #2 rst = 1;
    #1 chk("rst_async", int'({bus.grant_app, bus.grant_maint, bus.maint_sel, bus.aref_ack, bus.zq_ack,
                              bus.prd_ack, bus.aref_pending, bus.aref_overflow, bus.timeout_err}), 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 chk("rel_lat1", int'(bus.grant_app), 0);
    @(posedge clk); #1 chk("rel_lat2", int'(bus.grant_app), 1);
    @(negedge clk);
    bus.zq_req = 1; bus.prd_req = 1; bus.aref_req = 1;
    cyc(1);
    bus.zq_req = 0; bus.prd_req = 0; bus.aref_req = 0;
    chk("conc_pend", int'(bus.aref_pending), 1);
    cyc(7);
    bus.app_done = 1;
    cyc(1);
    bus.app_done = 0;
    serve("zq", 1'b0, 2'b10, 3'b010);
    serve("prd", 1'b0, 2'b11, 3'b001);
    serve("app", 1'b1, 2'b00, 3'b000);
    serve("aref", 1'b0, 2'b01, 3'b100);
    chk("aref_drain", int'(bus.aref_pending), 0);
    bus.app_req = 1;
    wait_grant("forced_app");
    chk("forced_app_gnt", int'(bus.grant_app), 1);
    repeat (MAXP) begin
      bus.aref_req = 1;
      cyc(1);
    end
    bus.aref_req = 0;
    chk("forced_pend8", int'(bus.aref_pending), 8);
    bus.app_done = 1;
    cyc(1);
    bus.app_done = 0;
    wait_grant("forced");
    chk("forced_maint", int'(bus.grant_maint), 1);
    chk("forced_sel", int'(bus.maint_sel), 1);
    chk("forced_pend7", int'(bus.aref_pending), 7);
    bus.app_req = 0;
    cyc(3);
    bus.dfi_init_complete = 0;
    bus.maint_done = 1;
    cyc(1);
    bus.maint_done = 0;
    cyc(2);
    bus.zq_req = 1;
    cyc(1);
    bus.zq_req = 0;
    cyc(4);
    chk("gate_idle", int'(bus.grant_app || bus.grant_maint), 0);
    bus.dfi_init_complete = 1;
    cyc(1);
    chk("gate_c1", int'(bus.grant_maint), 0);
    cyc(1);
    chk("gate_c2", int'(bus.grant_maint), 1);
    chk("gate_sel", int'(bus.maint_sel), 2);
    cyc(2);
    bus.dfi_init_complete = 0;
    bus.maint_done = 1;
    cyc(1);
    bus.maint_done = 0;
    cyc(1);
    bus.aref_req = 1;
    cyc(1);
    bus.aref_req = 0;
    chk("ovf_pend8", int'(bus.aref_pending), 8);
    chk("ovf_clear", int'(bus.aref_overflow), 0);
    bus.aref_req = 1;
    cyc(1);
    bus.aref_req = 0;
    chk("ovf_hold", int'(bus.aref_pending), 8);
    chk("ovf_set", int'(bus.aref_overflow), 1);
    cyc(5);
    chk("ovf_sticky", int'(bus.aref_overflow), 1);
    @(posedge clk); #1 rst = 1;
    #1 chk("ovf_reset", int'(bus.aref_overflow), 0);
    @(negedge clk) rst = 0;
    bus.dfi_init_complete = 1;
    bus.app_req = 1;
    wait_grant("to_app");
    bus.app_req = 0;
    n = 0;
    while (bus.grant_app && n < 40) begin
      cyc(1);
      n++;
    end
    chk("to_len", n, TO);
    chk("to_err", int'(bus.timeout_err), 1);
    bus.app_done = 1;
    cyc(1);
    bus.app_done = 0;
    cyc(2);
    chk("late_done", int'({bus.grant_app, bus.grant_maint}), 0);
    chk("late_err", int'(bus.timeout_err), 1);
    rst = 1;
    cyc(2);
    rst = 0;
    repeat (4000) begin
      if (bus.dfi_init_complete ? $urandom_range(0, 59) == 0 : $urandom_range(0, 5) == 0)
        bus.dfi_init_complete = !bus.dfi_init_complete;
      if ($urandom_range(0, 7) == 0) bus.app_req = !bus.app_req;
      bus.aref_req = $urandom_range(0, 5) == 0;
      bus.zq_req = $urandom_range(0, 29) == 0;
      bus.prd_req = $urandom_range(0, 29) == 0;
      bus.app_done = $urandom_range(0, 6) == 0;
      bus.maint_done = $urandom_range(0, 6) == 0;
      cyc(1);
    end
    bus.app_req = 0; bus.app_done = 0; bus.aref_req = 0;
    bus.zq_req = 0; bus.prd_req = 0; bus.maint_done = 0;
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
